// File: rtl/w_serial_fifo.sv
// w_serial_fifo: multi-channel weight buffer with bit-serial per-column readout.
// Ports: clk, rst (sync, active-high), precision (bits/weight; 0 or >W_MAX -> W_MAX),
//   wr_en/din (one packed word per channel), full, rd_en (per-channel bit strobe),
//   dout (show-ahead serial bit), empty, word_done, overflow (sticky), underflow (sticky).
// Optional: define W_SER_MSB_FIRST_EN to emit bits MSB-first within the precision.
module w_serial_fifo #(
  parameter int N     = 2,
  parameter int W_MAX = 8,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         precision,
  input  logic               wr_en,
  input  logic [N*W_MAX-1:0] din,
  output logic               full,
  input  logic [N-1:0]       rd_en,
  output logic [N-1:0]       dout,
  output logic [N-1:0]       empty,
  output logic [N-1:0]       word_done,
  output logic               overflow,
  output logic [N-1:0]       underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (W_MAX > 1) ? $clog2(W_MAX) : 1;
  localparam int PW = $clog2(W_MAX + 1);

  logic [W_MAX-1:0] mem [N][DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr [N];
  logic [CW-1:0]    count  [N];
  // pos always counts up from the start of a word; the emitted bit index is
  // derived from it so both bit orders share one boundary test.
  logic [BW-1:0]    pos    [N];
  logic [PW-1:0]    prec_q [N];

  logic [PW-1:0]    eff_in;
  logic [PW-1:0]    eff    [N];
  logic [BW-1:0]    idx    [N];
  logic [W_MAX-1:0] head   [N];
  logic [N-1:0]     last;
  logic [N-1:0]     rd_acc;
  logic [N-1:0]     pop;
  logic             wr_acc;

  always_comb begin
    if (precision == 4'd0 || int'(precision) > W_MAX) eff_in = PW'(W_MAX);
    else                                               eff_in = PW'(precision);
  end

  always_comb begin
    full   = 1'b0;
    empty  = '0;
    dout   = '0;
    last   = '0;
    rd_acc = '0;
    pop    = '0;
    for (int unsigned c = 0; c < N; c++) begin
      eff[c]  = (pos[c] == '0) ? eff_in : prec_q[c];
      head[c] = mem[c][rd_ptr[c]];
`ifdef W_SER_MSB_FIRST_EN
      idx[c]  = BW'(eff[c] - PW'(1) - PW'(pos[c]));
`else
      idx[c]  = pos[c];
`endif
      empty[c]  = (count[c] == '0);
      if (count[c] == CW'(DEPTH)) full = 1'b1;
      dout[c]   = empty[c] ? 1'b0 : head[c][idx[c]];
      last[c]   = (PW'(pos[c]) == eff[c] - PW'(1));
      rd_acc[c] = rd_en[c] & ~empty[c];
      pop[c]    = rd_acc[c] & last[c];
    end
    wr_acc = wr_en & ~full;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned c = 0; c < N; c++) mem[c][wr_ptr] <= din[c*W_MAX +: W_MAX];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      overflow  <= 1'b0;
      word_done <= '0;
      underflow <= '0;
      for (int unsigned c = 0; c < N; c++) begin
        rd_ptr[c] <= '0;
        count[c]  <= '0;
        pos[c]    <= '0;
        prec_q[c] <= '0;
      end
    end else begin
      if (wr_en && full) overflow <= 1'b1;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      word_done <= pop;
      for (int unsigned c = 0; c < N; c++) begin
        if (rd_en[c] && empty[c]) underflow[c] <= 1'b1;
        if (rd_acc[c]) begin
          if (pos[c] == '0) prec_q[c] <= eff_in;
          if (last[c]) begin
            pos[c]    <= '0;
            rd_ptr[c] <= rd_ptr[c] + AW'(1);
          end else begin
            pos[c] <= pos[c] + BW'(1);
          end
        end
        case ({wr_acc, pop[c]})
          2'b10:   count[c] <= count[c] + CW'(1);
          2'b01:   count[c] <= count[c] - CW'(1);
          default: count[c] <= count[c];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_w_serial_fifo.sv
module tb_w_serial_fifo;
  localparam int N     = 2;
  localparam int W_MAX = 8;
  localparam int DEPTH = 16;
  localparam int VW    = 4*N + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         precision;
  logic               wr_en;
  logic [N*W_MAX-1:0] din;
  logic               full;
  logic [N-1:0]       rd_en;
  logic [N-1:0]       dout;
  logic [N-1:0]       empty;
  logic [N-1:0]       word_done;
  logic               overflow;
  logic [N-1:0]       underflow;

  always #5 clk = ~clk;

  w_serial_fifo #(.N(N), .W_MAX(W_MAX), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .precision(precision), .wr_en(wr_en), .din(din),
    .full(full), .rd_en(rd_en), .dout(dout), .empty(empty),
    .word_done(word_done), .overflow(overflow), .underflow(underflow)
  );

  int checks   = 0;
  int failures = 0;

  typedef logic [W_MAX-1:0] word_t;
  word_t        q [N][$];
  int           pos_m [N];
  int           pm    [N];
  logic         ovf_m;
  logic [N-1:0] uf_m;
  logic [N-1:0] wd_m;

  logic [VW-1:0] act_vec;
  assign act_vec = {dout, empty, word_done, underflow, full, overflow};

  localparam logic [VW-1:0] RESET_VEC = {{N{1'b0}}, {N{1'b1}}, {N{1'b0}}, {N{1'b0}}, 1'b0, 1'b0};

  function automatic int effp(input logic [3:0] p);
    if (p == 4'd0 || int'(p) > W_MAX) return W_MAX;
    return int'(p);
  endfunction

  function automatic logic model_full();
    for (int c = 0; c < N; c++) if (q[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  // Expected {dout, empty, word_done, underflow, full, overflow} from the model.
  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] d, e;
    word_t h;
    int eff, bi;
    d = '0;
    e = '0;
    for (int c = 0; c < N; c++) begin
      if (q[c].size() == 0) e[c] = 1'b1;
      else begin
        eff = (pos_m[c] == 0) ? effp(precision) : pm[c];
`ifdef W_SER_MSB_FIRST_EN
        bi = eff - 1 - pos_m[c];
`else
        bi = pos_m[c];
`endif
        h = q[c][0];
        d[c] = h[bi];
      end
    end
    return {d, e, wd_m, uf_m, model_full(), ovf_m};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      q[c].delete();
      pos_m[c] = 0;
      pm[c]    = 0;
    end
    ovf_m = 1'b0;
    uf_m  = '0;
    wd_m  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = '0;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives one clock of stimulus and advances the reference model.
  task automatic cycle(input logic w, input logic [N*W_MAX-1:0] d,
                       input logic [N-1:0] r, input logic [3:0] p);
    logic fm;
    int eff;
    wr_en = w; din = d; rd_en = r; precision = p;
    fm = model_full();
    wd_m = '0;
    for (int c = 0; c < N; c++) begin
      if (r[c]) begin
        if (q[c].size() == 0) uf_m[c] = 1'b1;
        else begin
          eff = (pos_m[c] == 0) ? effp(p) : pm[c];
          if (pos_m[c] == 0) pm[c] = eff;
          if (pos_m[c] == eff - 1) begin
            void'(q[c].pop_front());
            pos_m[c] = 0;
            wd_m[c]  = 1'b1;
          end else pos_m[c]++;
        end
      end
    end
    if (w && fm) ovf_m = 1'b1;
    if (w && !fm) for (int c = 0; c < N; c++) q[c].push_back(d[c*W_MAX +: W_MAX]);
    @(posedge clk); #1;
  endtask

  function automatic logic [N*W_MAX-1:0] rand_din();
    logic [N*W_MAX-1:0] v;
    for (int c = 0; c < N; c++) v[c*W_MAX +: W_MAX] = W_MAX'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    precision = 4'd4; din = '0;
    do_reset();
    cycle(1'b0, '0, '0, 4'd4);
    checks++;
    if (act_vec !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_idle: got %b want %b", act_vec, RESET_VEC);
    end
  endtask

  task automatic test_basic();
    int s0 [4];
    int s1 [4];
`ifdef W_SER_MSB_FIRST_EN
    s0 = '{0, 1, 0, 1}; s1 = '{1, 1, 0, 0};
`else
    s0 = '{1, 0, 1, 0}; s1 = '{0, 0, 1, 1};
`endif
    do_reset();
    cycle(1'b1, {8'h0C, 8'h05}, '0, 4'd4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dout !== {s1[k][0], s0[k][0]}) begin
        failures++;
        $display("FAIL basic_bit%0d: dout got %b want %b", k, dout, {s1[k][0], s0[k][0]});
      end
      cycle(1'b0, '0, 2'b11, 4'd4);
    end
    checks++;
    if (word_done !== 2'b11 || empty !== 2'b11) begin
      failures++;
      $display("FAIL basic_done: word_done=%b empty=%b want 11 11", word_done, empty);
    end
    cycle(1'b0, '0, '0, 4'd4);
    checks++;
    if (act_vec !== exp_vec() || word_done !== 2'b00) begin
      failures++;
      $display("FAIL basic_done_pulse: got %b want %b", act_vec, exp_vec());
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_din(), '0, 4'd8);
      checks++;
      if (full !== 1'b1 || act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL fill_full p%0d: got %b want %b", pass, act_vec, exp_vec());
      end
      cycle(1'b1, rand_din(), '0, 4'd8);
      checks++;
      if (overflow !== 1'b1 || act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL fill_overflow p%0d: got %b want %b", pass, act_vec, exp_vec());
      end
      for (int b = 0; b < DEPTH*W_MAX; b++) begin
        cycle(1'b0, '0, 2'b11, 4'd8);
        checks++;
        if (act_vec !== exp_vec()) begin
          failures++;
          $display("FAIL drain p%0d bit%0d: got %b want %b", pass, b, act_vec, exp_vec());
        end
      end
      checks++;
      if (empty !== 2'b11) begin
        failures++;
        $display("FAIL drain_empty p%0d: empty got %b want 11", pass, empty);
      end
    end
  endtask

  task automatic test_skew();
    logic [N*W_MAX-1:0] d;
    do_reset();
    d = rand_din();
    cycle(1'b1, d, '0, 4'd4);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0, 2'b01, 4'd4);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL skew_rd%0d: got %b want %b", k, act_vec, exp_vec());
      end
    end
    checks++;
    if (empty !== 2'b01 || dout[1] !== d[W_MAX]) begin
      failures++;
      $display("FAIL skew_ch1_hold: empty=%b dout1=%b want 01 %b", empty, dout[1], d[W_MAX]);
    end
    cycle(1'b0, '0, 2'b01, 4'd4);
    checks++;
    if (underflow !== 2'b01 || act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL skew_underflow: got %b want %b", act_vec, exp_vec());
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0, 2'b10, 4'd4);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL skew_ch1_rd%0d: got %b want %b", k, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_prec_change();
    logic [3:0] pseq [6];
    logic [N-1:0] wdx [6];
    pseq = '{4'd4, 4'd4, 4'd2, 4'd2, 4'd2, 4'd2};
    wdx  = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11};
    do_reset();
    cycle(1'b1, rand_din(), '0, 4'd4);
    cycle(1'b1, rand_din(), '0, 4'd4);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, '0, 2'b11, pseq[k]);
      checks++;
      if (act_vec !== exp_vec() || word_done !== wdx[k]) begin
        failures++;
        $display("FAIL prec_change rd%0d: got %b want %b (word_done want %b)",
                 k, act_vec, exp_vec(), wdx[k]);
      end
    end
    checks++;
    if (empty !== 2'b11) begin
      failures++;
      $display("FAIL prec_change_empty: got %b want 11", empty);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, rand_din(), '0, 4'd8);
    cycle(1'b0, '0, 2'b11, 4'd8);
    cycle(1'b0, '0, 2'b11, 4'd8);
    cycle(1'b0, '0, 2'b00, 4'd8);
    do_reset();
    checks++;
    if (act_vec !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_mid: got %b want %b", act_vec, RESET_VEC);
    end
    cycle(1'b1, rand_din(), '0, 4'd8);
    for (int k = 0; k < W_MAX; k++) begin
      cycle(1'b0, '0, 2'b11, 4'd8);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL reset_mid_after rd%0d: got %b want %b", k, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] p;
    logic w;
    do_reset();
    p = 4'd3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) p = 4'($urandom_range(0, 11));
      // Alternate write-heavy and read-heavy phases to reach full and empty.
      if ((i / 200) % 2 == 0) w = ($urandom_range(0, 3) != 0);
      else                    w = ($urandom_range(0, 7) == 0);
      cycle(w, rand_din(), N'($urandom), p);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc%0d: got %b want %b", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = '0; din = '0; precision = 4'd4;
    #1;
    test_reset();
    test_basic();
    test_fill_drain();
    test_skew();
    test_prec_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/w_serial_fifo.md
Name: w_serial_fifo

Overview:
- Multi-channel weight buffer for the systolic mm datapath. Accepts packed multi-bit weight words, one word per column per write. Emits each word bit-serially to the column PEs at a runtime-selected precision.
- Replaces the single-bit per-column weight FIFO, so hosts no longer pre-serialise weights.
- Sits between the host write port and the systolic array's per-column w_in. Read strobes come from the array's active_column.

Parameters:
- N, 2, number of columns (independent read channels).
- W_MAX, 8, maximum weight precision in bits; word width per channel.
- DEPTH, 16, words per channel; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- precision  in  4  bits per weight, valid range 1..W_MAX; 0 or >W_MAX treated as W_MAX.
- wr_en  in  1  write one word into every channel simultaneously.
- din  in  N*W_MAX  packed words; channel c uses din[c*W_MAX +: W_MAX]; weight LSB at bit 0.
- full  out  1  high when any channel holds DEPTH words.
- rd_en  in  N  per-channel bit-read strobe (active_column).
- dout  out  N  current serial bit per channel (show-ahead).
- empty  out  N  channel holds no words.
- word_done  out  N  registered one-cycle pulse after a channel's last bit of a word is consumed.
- overflow  out  1  sticky; wr_en seen while full.
- underflow  out  N  sticky per channel; rd_en seen while empty.

Behaviour:
- Reset (rst=1 at posedge): all pointers, counts and bit pointers cleared. Reset values: full=0, empty=all 1, word_done=0, overflow=0, underflow=0, dout=0. Reset mid-word discards all contents and partial progress.
- Storage: per channel, circular buffer of DEPTH x W_MAX. Write pointer is shared, read pointers are per channel. Pointers wrap modulo DEPTH. Count width is clog2(DEPTH+1).
- Write: when wr_en=1 and full=0 at posedge, each channel stores its slice and increments its count.
  - When wr_en=1 and full=1, nothing is written in any channel and overflow is set.
  - There is no write-through: data written on an empty channel appears on dout the next cycle.
- Read state per channel: bit_ptr (0..W_MAX-1) and prec_q (latched precision).
  - dout[c] = head_word[bit_ptr] while not empty; dout[c] = 0 when empty.
  - At bit_ptr=0, the effective precision comes straight from the precision input. On an accepted read at bit_ptr=0, that value is latched into prec_q and held for the rest of the word.
- Accepted read is rd_en[c]=1 and empty[c]=0:
  - if bit_ptr == effective_prec-1: bit_ptr<=0, pop word (read pointer+1, count-1), word_done[c]<=1 next cycle.
  - else: bit_ptr<=bit_ptr+1.
  - Precision 1 pops on every accepted read.
- rd_en[c] on an empty channel: ignored, bit_ptr unchanged, underflow[c] set.
- Simultaneous write and pop on the same channel: count unchanged, both take effect.
- full is derived from the registered counts (any count==DEPTH). A pop in the same cycle does not unblock a write.
- Changing precision mid-word has no effect until the next word boundary.
- Channels advance independently, so skewed column activation from the array is supported.
- Latency: write to first dout bit is 1 cycle. Each bit is consumed in 1 cycle, with no bubbles between words.

Optional Feature:
- Macro W_SER_MSB_FIRST_EN.
- When defined: bits are emitted MSB-first within the effective precision. The first bit is word[effective_prec-1], then descending to word[0]. bit_ptr counts down from effective_prec-1, and the pop occurs after bit 0.
- When undefined: LSB-first, as described in Behaviour.
- Pop timing, word_done and all flags are identical in both modes.

Test Plan:
- Reset then idle: full=0, empty=2'b11, dout=0, all flags 0.
- Setup: N=2, precision=4, write din={8'h0C,8'h05}.
  - Four rd_en=2'b11 cycles give ch0 dout 1,0,1,0 and ch1 dout 0,0,1,1.
  - word_done=2'b11 for exactly one cycle after the 4th read; empty=2'b11 afterwards.
  - With W_SER_MSB_FIRST_EN the sequences are ch0 0,1,0,1 and ch1 1,1,0,0.
- Write 16 words: full=1 on the cycle after the 16th write. A 17th write sets overflow=1 and the contents are unchanged.
  - Read all back at precision=8: 128 bits match in order and pointers wrap correctly.
  - A second fill-and-drain also passes.
- Precision=4 and rd_en only on ch0 for 4 cycles: ch0 pops while ch1 still shows its word[0].
  - rd_en on empty ch0 sets underflow=2'b01.
- Change precision 4->2 after 2 bits of a word: the word still emits 4 bits. The next word emits 2 bits and then pops.
- Assert rst after 2 bits mid-word while full: next cycle empty=all 1, full=0, flags cleared. A subsequent write/read works normally.
